dmem_ctrl_arbiter: RTL and testbench

Sequencing controller and two-port arbiter in front of the single-port word-wide data memory. It shares the memory between the core load/store unit (port C) and a DMA/debug master (port D) using round-robin arbitration. It implements RISC-V byte/halfword loads with sign/zero extension. Sub-word stores are done as read-modify-write, because the memory only writes whole words.

---
 rtl/dmem_ctrl_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_ctrl_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dmem_ctrl_arbiter: round-robin core/DMA arbiter and sequencer for a       |
// | single-port word memory (sub-word loads, read-modify-write stores). r1.0  |
// +---------------------------------------------------------------------------+
module dmem_ctrl_arbiter #(
    parameter int MEM_AW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [2:0]  c_size,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_ack,
    output logic        c_err,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_access_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_en,
    output logic        mem_read,
    input  logic [31:0] mem_read_data,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              rr_last;
    logic              lat_port;
    logic              lat_we;
    logic              lat_err;
    logic [2:0]        lat_size;
    logic [MEM_AW+1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       load_res;
    logic [31:0]       merge_word;

    logic              grant_valid;
    logic              grant_port;
    logic              sel_we;
    logic              sel_err;
    logic [2:0]        sel_size;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              store_word;
    logic              store_sub;
    logic [4:0]        lane_shift;
    logic [31:0]       lane_data;
    logic [31:0]       lane_mask;
    logic [31:0]       ext_data;
    logic [31:0]       merged_data;
    logic              unused_addr_bits;

    function automatic logic access_bad(input logic we, input logic [2:0] size,
                                        input logic [1:0] a);
        logic bad;
        case (size)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_valid = c_req | d_req;
        grant_port  = (c_req & d_req) ? ~rr_last : d_req;
        sel_we      = grant_port ? d_we    : c_we;
        sel_size    = grant_port ? d_size  : c_size;
        sel_addr    = grant_port ? d_addr  : c_addr;
        sel_wdata   = grant_port ? d_wdata : c_wdata;
        sel_err     = access_bad(sel_we, sel_size, sel_addr[1:0]);
    end

    assign unused_addr_bits = ^sel_addr[31:MEM_AW+2];

    always_comb begin
        store_word  = lat_we & (lat_size == 3'b010);
        store_sub   = lat_we & (lat_size != 3'b010);
        lane_shift  = {lat_addr[1:0], 3'b000};
        lane_data   = mem_read_data >> lane_shift;
        case (lat_size[1:0])
            2'b00:   ext_data = {{24{~lat_size[2] & lane_data[7]}}, lane_data[7:0]};
            2'b01:   ext_data = {{16{~lat_size[2] & lane_data[15]}}, lane_data[15:0]};
            default: ext_data = mem_read_data;
        endcase
        lane_mask   = (lat_size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
        merged_data = (mem_read_data & ~lane_mask) | ((lat_wdata << lane_shift) & lane_mask);
    end

    always_comb begin
        state_nxt      = state;
        mem_read       = 1'b0;
        mem_write_en   = 1'b0;
        mem_write_data = 32'h0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = sel_err ? RESP : XFER;
                end
            end
            XFER: begin
                if (store_word) begin
                    mem_write_en   = 1'b1;
                    mem_write_data = lat_wdata;
                    state_nxt      = RESP;
                end else begin
                    mem_read  = 1'b1;
                    state_nxt = store_sub ? MERGE_WR : RESP;
                end
            end
            MERGE_WR: begin
                mem_write_en   = 1'b1;
                mem_write_data = merge_word;
                state_nxt      = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_access_addr = {{(32-MEM_AW){1'b0}}, lat_addr[MEM_AW+1:2]};
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last    <= PORT_D;
            lat_port   <= PORT_C;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_size   <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= 32'h0;
            load_res   <= 32'h0;
            merge_word <= 32'h0;
            c_ack      <= 1'b0;
            c_err      <= 1'b0;
            c_rdata    <= 32'h0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= 32'h0;
        end else begin
            c_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        rr_last   <= grant_port;
                        lat_port  <= grant_port;
                        lat_we    <= sel_we;
                        lat_size  <= sel_size;
                        lat_addr  <= sel_addr[MEM_AW+1:0];
                        lat_wdata <= sel_wdata;
                        lat_err   <= sel_err;
                    end
                end
                XFER: begin
                    if (!lat_we) begin
                        load_res <= ext_data;
                    end else if (store_sub) begin
                        merge_word <= merged_data;
                    end
                end
                RESP: begin
                    // Stores and rejected requests leave rdata untouched.
                    if (lat_port == PORT_D) begin
                        d_ack <= 1'b1;
                        d_err <= lat_err;
                        if (!lat_we && !lat_err) d_rdata <= load_res;
                    end else begin
                        c_ack <= 1'b1;
                        c_err <= lat_err;
                        if (!lat_we && !lat_err) c_rdata <= load_res;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl_arbiter.sv
`default_nettype none
// Scoreboard bench for dmem_ctrl_arbiter: drivers push expected responses,
// a monitor pops and compares on every ack.
module tb_dmem_ctrl_arbiter;
    localparam int NW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [2:0]  c_size = 3'b0, d_size = 3'b0;
    logic [31:0] c_addr = 32'h0, c_wdata = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic        c_ack, c_err, d_ack, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read, busy;

    always #5 clk = ~clk;

    dmem_ctrl_arbiter #(.MEM_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic [31:0] mem [NW];
    logic [31:0] ref_mem [NW];
    logic [31:0] model_rd [2];
    exp_t        exp_c [$];
    exp_t        exp_d [$];
    int          n_cmp = 0, n_err = 0;
    int          wr_cnt = 0, rd_cnt = 0;
    logic [31:0] wr_last = 32'h0;
    int          cyc = 0, last_ack_cyc = -100, last_ack_port = 1;
    logic        fair_mode = 1'b0;

    assign mem_read_data = mem[mem_access_addr[4:0]];

    initial forever begin
        @(posedge clk);
        if (mem_write_en) begin
            mem[mem_access_addr[4:0]] = mem_write_data;
            wr_cnt++;
            wr_last = mem_write_data;
        end
        if (mem_read) rd_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-lane arithmetic on a shadow memory.
    function automatic exp_t model(input int p, input logic we, input logic [2:0] size,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          idx, sh, nb;
        logic [31:0] w, v, m;
        logic        legal, mis;
        legal = (size == 0 || size == 1 || size == 2 || size == 4 || size == 5) && !(we && size >= 4);
        nb    = (size == 2) ? 4 : ((size == 1 || size == 5) ? 2 : 1);
        mis   = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
        e.err = !legal || mis;
        idx   = int'(addr[6:2]);
        sh    = 8 * int'(addr[1:0]);
        w     = ref_mem[idx];
        if (!e.err) begin
            if (!we) begin
                v = w >> sh;
                if (nb == 1) begin
                    v = v & 32'hFF;
                    if (size == 0 && v[7]) v = v | 32'hFFFF_FF00;
                end else if (nb == 2) begin
                    v = v & 32'hFFFF;
                    if (size == 1 && v[15]) v = v | 32'hFFFF_0000;
                end
                model_rd[p] = v;
            end else begin
                m = (nb == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * nb)) - 1) << sh);
                ref_mem[idx] = (w & ~m) | ((wdata << sh) & m);
            end
        end
        e.rdata = model_rd[p];
        return e;
    endfunction

    task automatic check_ack(input int p);
        exp_t e;
        if (p == 0 && exp_c.size() == 0 || p == 1 && exp_d.size() == 0) begin
            chk(p == 0 ? "unexpected_c_ack" : "unexpected_d_ack", 32'h1, 32'h0);
            return;
        end
        e = (p == 0) ? exp_c.pop_front() : exp_d.pop_front();
        chk(p == 0 ? "c_err" : "d_err", {31'b0, p == 0 ? c_err : d_err}, {31'b0, e.err});
        chk(p == 0 ? "c_rdata" : "d_rdata", p == 0 ? c_rdata : d_rdata, e.rdata);
        if (fair_mode) begin
            chk("fair_order", p, 1 - last_ack_port);
            chk("fair_gap", {31'b0, (cyc - last_ack_cyc) >= 3}, 32'h1);
        end
        last_ack_port = p;
        last_ack_cyc  = cyc;
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (c_ack && d_ack) chk("ack_overlap", 32'h1, 32'h0);
            if (c_ack) check_ack(0);
            if (d_ack) check_ack(1);
        end
    end

    task automatic drive(input int p, input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            c_we = we; c_size = size; c_addr = addr; c_wdata = wdata; c_req = req;
        end else begin
            d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; d_req = req;
        end
    endtask

    // One transaction; called at negedge time. exp_lat=0 skips the latency check.
    task automatic xact(input int p, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
        exp_t e;
        int   cnt;
        logic got;
        e = model(p, we, size, addr, wdata);
        if (p == 0) exp_c.push_back(e); else exp_d.push_back(e);
        drive(p, 1'b1, we, size, addr, wdata);
        cnt = 0;
        got = 1'b0;
        while (cnt < 100 && !got) begin
            @(negedge clk);
            cnt++;
            if (rst_n && (p == 0 ? c_ack : d_ack)) got = 1'b1;
        end
        if (!got) chk("ack_timeout", 32'h0, 32'h1);
        else if (exp_lat > 0) chk("latency", cnt, exp_lat);
        drive(p, 1'b0, we, size, addr, wdata);
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    task automatic rand_ops(input int p, input int n);
        logic        we;
        logic [2:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    sz = 3'b000;
                2, 3:    sz = 3'b001;
                4, 5:    sz = 3'b010;
                6:       sz = 3'b100;
                7:       sz = 3'b101;
                8:       sz = 3'b011;
                default: sz = 3'b111;
            endcase
            a = $urandom;
            a[6] = (p == 1);
            if ($urandom_range(0, 3) != 0) begin
                if (sz[1:0] == 2'b01) a[0] = 1'b0;
                if (sz == 3'b010) a[1:0] = 2'b00;
            end
            xact(p, we, sz, a, $urandom, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic fair_loads(input int p, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            a[6] = (p == 1);
            a[1:0] = 2'b00;
            xact(p, 1'b0, 3'b010, a, 32'h0, 0);
        end
    endtask

    initial begin
        int w0, r0, k;
        for (int i = 0; i < NW; i++) set_word(i, $urandom);
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_c_out", {c_ack, c_err, 30'b0} | c_rdata, 32'h0);
        chk("rst_d_out", {d_ack, d_err, 30'b0} | d_rdata, 32'h0);
        chk("rst_mem_out", {mem_write_en, mem_read, busy, 29'b0} | mem_access_addr | mem_write_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        set_word(2, 32'h0000_0001);
        w0 = wr_cnt;
        xact(0, 1'b0, 3'b010, 32'h8, 32'h0, 3);
        chk("lw_no_write", wr_cnt - w0, 0);
        chk("lw_value", c_rdata, 32'h0000_0001);

        set_word(1, 32'h8000_0002);
        xact(0, 1'b0, 3'b000, 32'h7, 32'h0, 3);
        chk("lb_value", c_rdata, 32'hFFFF_FF80);
        xact(0, 1'b0, 3'b100, 32'h7, 32'h0, 3);
        chk("lbu_value", c_rdata, 32'h0000_0080);
        xact(0, 1'b0, 3'b001, 32'h6, 32'h0, 3);
        chk("lh_value", c_rdata, 32'hFFFF_8000);

        set_word(1, 32'h0000_0002);
        w0 = wr_cnt;
        xact(1, 1'b1, 3'b000, 32'h5, 32'h0000_00AB, 4);
        chk("sb_write_count", wr_cnt - w0, 1);
        chk("sb_write_data", wr_last, 32'h0000_AB02);
        xact(1, 1'b0, 3'b010, 32'h4, 32'h0, 3);
        chk("sb_readback", d_rdata, 32'h0000_AB02);
        xact(1, 1'b1, 3'b010, 32'h4C, 32'h1234_5678, 3);

        w0 = wr_cnt;
        r0 = rd_cnt;
        xact(0, 1'b0, 3'b010, 32'h6, 32'h0, 2);
        xact(0, 1'b1, 3'b101, 32'h10, 32'h5555, 2);
        xact(0, 1'b0, 3'b011, 32'h0, 32'h0, 2);
        chk("err_no_read", rd_cnt - r0, 0);
        chk("err_no_write", wr_cnt - w0, 0);

        // Abort an SH while its merged word is on the write strobe.
        set_word(3, 32'h1122_3344);
        drive(0, 1'b1, 1'b1, 3'b001, 32'hE, 32'h0000_BEEF);
        k = 0;
        while (k < 10 && !mem_write_en) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reached_merge", {31'b0, mem_write_en}, 32'h1);
        chk("abort_busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_drop", {31'b0, mem_write_en}, 32'h0);
        drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_ack", {30'b0, c_ack, d_ack}, 32'h0);
        chk("abort_mem_kept", mem[3], 32'h1122_3344);
        chk("abort_idle", {31'b0, busy}, 32'h0);
        xact(0, 1'b0, 3'b010, 32'hC, 32'h0, 3);

        // Both ports request continuously from reset.
        rst_n = 1'b0;
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        last_ack_port = 1;
        fair_mode = 1'b1;
        fork
            fair_loads(0, 6);
            fair_loads(1, 6);
            begin
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        fair_mode = 1'b0;
        repeat (2) @(negedge clk);

        fork
            rand_ops(0, 40);
            rand_ops(1, 40);
        join
        repeat (3) @(negedge clk);
        chk("queues_drained", exp_c.size() + exp_d.size(), 0);
        for (int i = 0; i < NW; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
